mult_div_unit: RTL

Multicycle signed multiply/divide responder for the MIPS datapath. The control unit issues a one-cycle `start` with operands from A/B and an operation select. This block runs a 32-iteration Booth multiply or restoring divide, then returns a one-cycle `done` with results in HI/LO. It sits beside the ALU and is read by the MFHI/MFLO paths.

---
 rtl/ctrl_pkg.sv | 17 +
 rtl/md_step.sv | 61 ++++++
 rtl/mult_div_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared constants and state encoding for the multiply/divide unit
package ctrl_pkg;

  localparam int WIDTH    = 32;
  localparam int MD_ITERS = WIDTH;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MULT   = 2'd1,
    S_DIV    = 2'd2,
    S_FINISH = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one Booth add/shift or restoring-divide trial step on a shared adder
module md_step
  import ctrl_pkg::*;
#(
  parameter int W = ctrl_pkg::WIDTH
) (
  input  logic         op,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] lo_w,
  input  logic         q_m1,
  input  logic [W-1:0] operand,
  output logic [W-1:0] next_acc,
  output logic [W-1:0] next_lo,
  output logic         next_q_m1
);

  logic [W+1:0] lhs;
  logic [W+1:0] rhs;
  logic [W+1:0] sum;
  logic         sub;

  always_comb begin
    lhs       = '0;
    rhs       = '0;
    sub       = 1'b0;
    next_acc  = acc;
    next_lo   = lo_w;
    next_q_m1 = q_m1;
    if (op == MD_MULT) begin
      // Two guard bits keep acc +/- operand exact even for the most negative operand.
      lhs = {{2{acc[W-1]}}, acc};
      case ({lo_w[0], q_m1})
        2'b01:   rhs = {{2{operand[W-1]}}, operand};
        2'b10: begin
          rhs = {{2{operand[W-1]}}, operand};
          sub = 1'b1;
        end
        default: rhs = '0;
      endcase
    end else begin
      lhs = {1'b0, acc, lo_w[W-1]};
      rhs = {2'b00, operand};
      sub = 1'b1;
    end

    sum = lhs + (sub ? ~rhs : rhs) + {{(W+1){1'b0}}, sub};

    if (op == MD_MULT) begin
      next_acc  = sum[W:1];
      next_lo   = {sum[0], lo_w[W-1:1]};
      next_q_m1 = lo_w[0];
    end else if (!sum[W+1]) begin
      next_acc = sum[W-1:0];
      next_lo  = {lo_w[W-2:0], 1'b1};
    end else begin
      next_acc = {acc[W-2:0], lo_w[W-1]};
      next_lo  = {lo_w[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed Booth multiply / restoring divide with HI/LO results
module mult_div_unit #(
  parameter int WIDTH = ctrl_pkg::MD_ITERS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import ctrl_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc, lo_w, operand;
  logic             q_m1, op_r, zero_r, neg_q, neg_r, last;
  logic [WIDTH-1:0] next_acc, next_lo;
  logic             next_q_m1;

  assign last = (count == CNT_W'(WIDTH - 1));

  md_step #(.W(WIDTH)) u_step (
    .op        (op_r),
    .acc       (acc),
    .lo_w      (lo_w),
    .q_m1      (q_m1),
    .operand   (operand),
    .next_acc  (next_acc),
    .next_lo   (next_lo),
    .next_q_m1 (next_q_m1)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE:   if (start) state_next = (op == MD_MULT) ? S_MULT : S_DIV;
      S_MULT:   if (last) state_next = S_FINISH;
      // A zero divisor skips the iterations but still spends one cycle here.
      S_DIV:    if (last || zero_r) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      lo_w     <= '0;
      operand  <= '0;
      q_m1     <= 1'b0;
      op_r     <= 1'b0;
      zero_r   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          op_r   <= op;
          count  <= '0;
          acc    <= '0;
          q_m1   <= 1'b0;
          zero_r <= (op == MD_DIV) && (b == '0);
          neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r  <= a[WIDTH-1];
          if (op == MD_MULT) begin
            operand <= a;
            lo_w    <= b;
          end else begin
            operand <= b[WIDTH-1] ? (~b + 1'b1) : b;
            lo_w    <= a[WIDTH-1] ? (~a + 1'b1) : a;
          end
        end
        S_MULT, S_DIV: begin
          acc   <= next_acc;
          lo_w  <= next_lo;
          q_m1  <= next_q_m1;
          count <= count + 1'b1;
        end
        S_FINISH: begin
          done <= 1'b1;
          if (zero_r) begin
            div_zero <= 1'b1;
          end else if (op_r == MD_MULT) begin
            hi <= acc;
            lo <= lo_w;
          end else begin
            hi <= neg_r ? (~acc + 1'b1) : acc;
            lo <= neg_q ? (~lo_w + 1'b1) : lo_w;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
